// File: rtl/spi_bridge_pkg.sv
// spi_bridge_pkg
//   Shared types and constants for the SPI-byte to register-bus bridge:
//   FSM state encoding, command byte field positions, the flag-clear command
//   and the bit positions of the status byte returned on tx_byte.
package spi_bridge_pkg;

   typedef enum logic [2:0] {
      S_CMD   = 3'd0,
      S_ADDR  = 3'd1,
      S_WDATA = 3'd2,
      S_WBUS  = 3'd3,
      S_RBUS  = 3'd4,
      S_RDATA = 3'd5
   } state_t;

   localparam int         CMD_WR_BIT  = 7;
   localparam int         CMD_LEN_MSB = 6;
   localparam int         CMD_LEN_LSB = 4;
   localparam logic [7:0] CMD_CLR     = 8'hFF;

   localparam int ST_OVR  = 3;
   localparam int ST_ERR  = 2;
   localparam int ST_TMO  = 1;
   localparam int ST_BUSY = 0;

   function automatic logic [7:0] status_byte(input logic [3:0] tag,
                                              input logic       ovr,
                                              input logic       err,
                                              input logic       tmo,
                                              input logic       busy);
      logic [7:0] s;
      s          = 8'h00;
      s[7:4]     = tag;
      s[ST_OVR]  = ovr;
      s[ST_ERR]  = err;
      s[ST_TMO]  = tmo;
      s[ST_BUSY] = busy;
      return s;
   endfunction

endpackage

// File: rtl/spi_bridge_if.sv
// spi_bridge_if
//   Register-bus handshake between the bridge (master) and the register bank (slave).
//   bus_req   master->slave  request, held until bus_ack
//   bus_we    master->slave  1 = write, 0 = read
//   bus_addr  master->slave  register address (ADDR_W bits)
//   bus_wdata master->slave  write data
//   bus_rdata slave->master  read data, valid with bus_ack
//   bus_ack   slave->master  one-cycle completion strobe
interface spi_bridge_if #(
   parameter int unsigned ADDR_W = 8
);
   logic              bus_req;
   logic              bus_we;
   logic [ADDR_W-1:0] bus_addr;
   logic [7:0]        bus_wdata;
   logic [7:0]        bus_rdata;
   logic              bus_ack;

   modport master (
      output bus_req, bus_we, bus_addr, bus_wdata,
      input  bus_rdata, bus_ack
   );

   modport slave (
      input  bus_req, bus_we, bus_addr, bus_wdata,
      output bus_rdata, bus_ack
   );
endinterface

// File: rtl/spi_bridge_timeout.sv
// spi_bridge_timeout
//   Idle watchdog for a partially received frame. Down-counter reloads whenever
//   disabled or cleared; expire_o pulses on the TIMEOUT_CYC-th consecutive enabled,
//   uncleared cycle. Only instantiated when SPI_BRIDGE_TIMEOUT_EN is defined.
//   clk       system clock
//   reset_n   asynchronous active-low reset
//   en_i      counting allowed (frame in progress, no bus op in flight)
//   clr_i     activity seen (byte event or bus ack), restart the count
//   expire_o  one-cycle expiry pulse
module spi_bridge_timeout #(
   parameter int unsigned TIMEOUT_CYC = 4096
) (
   input  logic clk,
   input  logic reset_n,
   input  logic en_i,
   input  logic clr_i,
   output logic expire_o
);
   localparam int unsigned    CW   = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CW-1:0]  LOAD = CW'(TIMEOUT_CYC);

   logic [CW-1:0] cnt_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= LOAD;
      end else if (clr_i || !en_i) begin
         cnt_q <= LOAD;
      end else if (cnt_q != '0) begin
         cnt_q <= cnt_q - CW'(1);
      end
   end

   assign expire_o = en_i && !clr_i && (cnt_q == CW'(1));
endmodule

// File: rtl/spi_reg_bridge.sv
// spi_reg_bridge
//   Turns the byte-per-SS-frame stream from the SPI slave into register-bus
//   reads/writes. Frame: CMD, ADDR, then cmd[6:4]+1 data bytes (cmd[7]=1 write).
//   cmd 8'hFF clears the sticky flags; any other cmd with cmd[3:0]!=0 is rejected.
//   tx_byte carries read data after a read completes, otherwise the status byte
//   {STATUS_TAG, ovr, err_cmd, tmo, busy}; it only moves on bridge transitions.
//   Optional macro SPI_BRIDGE_TIMEOUT_EN: abort a stalled partial frame after
//   TIMEOUT_CYC idle cycles and set tmo. Undefined: tmo reads 0, no abort.
// Ports
//   clk       system clock
//   reset_n   asynchronous active-low reset
//   rx_byte   received byte, valid while rx_done high
//   rx_done   level; rising edge marks one new byte
//   tx_byte   byte preloaded by the SPI slave at next SS fall
//   bus       register-bus master (bus_req/we/addr/wdata out, bus_rdata/ack in)
//
// state   | meaning
// S_CMD   | idle, waiting for command byte
// S_ADDR  | command accepted, waiting for address byte
// S_WDATA | waiting for next write data byte
// S_WBUS  | write in progress on register bus
// S_RBUS  | read in progress on register bus
// S_RDATA | read data on tx_byte, waiting for dummy byte
module spi_reg_bridge
   import spi_bridge_pkg::*;
#(
   parameter int unsigned ADDR_W      = 8,
   parameter int unsigned TIMEOUT_CYC = 4096,
   parameter logic [3:0]  STATUS_TAG  = 4'hA
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic [7:0]   rx_byte,
   input  logic         rx_done,
   output logic [7:0]   tx_byte,
   spi_bridge_if.master bus
);
   state_t            state_q, state_d;
   logic              rx_done_q;
   logic [2:0]        cnt_q, cnt_d;
   logic              req_q, req_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [7:0]        wdata_q, wdata_d;
   logic [7:0]        tx_q, tx_d;
   logic              ovr_q, ovr_d;
   logic              err_q, err_d;
   logic              tmo_q, tmo_d;
   logic              byte_evt;
   logic              ack_evt;
   logic              tmo_expire;
   logic              rd_load;
   logic              cmd_evt;

   assign byte_evt = rx_done && !rx_done_q;
   assign ack_evt  = req_q && bus.bus_ack;

`ifdef SPI_BRIDGE_TIMEOUT_EN
   spi_bridge_timeout #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_timeout (
      .clk      (clk),
      .reset_n  (reset_n),
      .en_i     ((state_q != S_CMD) && !req_q),
      .clr_i    (byte_evt || ack_evt),
      .expire_o (tmo_expire)
   );
`else
   assign tmo_expire = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      req_d   = req_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      tx_d    = tx_q;
      ovr_d   = ovr_q;
      err_d   = err_q;
      tmo_d   = tmo_q;
      rd_load = 1'b0;
      cmd_evt = 1'b0;

      // Bus completion is resolved first so a same-cycle byte sees the new state.
      if (ack_evt) begin
         req_d  = 1'b0;
         addr_d = addr_q + ADDR_W'(1);
         if (state_q == S_RBUS) begin
            state_d = S_RDATA;
            rd_load = 1'b1;
         end else if (cnt_q == 3'd0) begin
            state_d = S_CMD;
         end else begin
            cnt_d   = cnt_q - 3'd1;
            state_d = S_WDATA;
         end
      end else if (!req_q && (state_q == S_WBUS || state_q == S_RBUS)) begin
         req_d = 1'b1;
      end

      if (byte_evt) begin
         unique case (state_d)
            S_CMD: begin
               cmd_evt = 1'b1;
               if (rx_byte == CMD_CLR) begin
                  ovr_d = 1'b0;
                  err_d = 1'b0;
                  tmo_d = 1'b0;
               end else if (rx_byte[3:0] != 4'h0) begin
                  err_d = 1'b1;
               end else begin
                  we_d    = rx_byte[CMD_WR_BIT];
                  cnt_d   = rx_byte[CMD_LEN_MSB:CMD_LEN_LSB];
                  state_d = S_ADDR;
               end
            end
            S_ADDR: begin
               addr_d  = ADDR_W'(rx_byte);
               state_d = we_d ? S_WDATA : S_RBUS;
            end
            S_WDATA: begin
               wdata_d = rx_byte;
               state_d = S_WBUS;
            end
            S_RDATA: begin
               rd_load = 1'b0;
               if (cnt_d != 3'd0) begin
                  cnt_d   = cnt_d - 3'd1;
                  state_d = S_RBUS;
               end else begin
                  state_d = S_CMD;
               end
            end
            default: begin
               // Bus op still in flight: drop the byte, flag it, let the op finish.
               ovr_d = 1'b1;
            end
         endcase
      end

      // Expiry can only fire with no bus op in flight and no activity this cycle.
      if (tmo_expire && (TIMEOUT_CYC != 0)) begin
         state_d = S_CMD;
         req_d   = 1'b0;
         tmo_d   = 1'b1;
      end

      if (rd_load) begin
         tx_d = bus.bus_rdata;
      end else if (state_d != state_q || cmd_evt) begin
         tx_d = status_byte(STATUS_TAG, ovr_d, err_d, tmo_d, state_d != S_CMD);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= S_CMD;
         rx_done_q <= 1'b0;
         cnt_q     <= 3'd0;
         req_q     <= 1'b0;
         we_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= 8'h00;
         tx_q      <= {STATUS_TAG, 4'b0000};
         ovr_q     <= 1'b0;
         err_q     <= 1'b0;
         tmo_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         rx_done_q <= rx_done;
         cnt_q     <= cnt_d;
         req_q     <= req_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         tx_q      <= tx_d;
         ovr_q     <= ovr_d;
         err_q     <= err_d;
         tmo_q     <= tmo_d;
      end
   end

   assign bus.bus_req   = req_q;
   assign bus.bus_we    = we_q;
   assign bus.bus_addr  = addr_q;
   assign bus.bus_wdata = wdata_q;
   assign tx_byte       = tx_q;
endmodule

// File: tb/tb_spi_reg_bridge.sv
`timescale 1ns/1ps
module tb_spi_reg_bridge;
   logic       clk     = 1'b0;
   logic       reset_n = 1'b0;
   logic [7:0] rx_byte = 8'h00;
   logic       rx_done = 1'b0;
   logic [7:0] tx_byte;

   spi_bridge_if #(.ADDR_W(8)) bus_if ();

   spi_reg_bridge #(
      .ADDR_W      (8),
      .TIMEOUT_CYC (4096),
      .STATUS_TAG  (4'hA)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .rx_byte (rx_byte),
      .rx_done (rx_done),
      .tx_byte (tx_byte),
      .bus     (bus_if.master)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       we;
      logic [7:0] addr;
      logic [7:0] data;
   } txn_t;

   txn_t       exp_q[$];
   logic [7:0] mem [256];
   int         ack_delay = 2;
   int         n_chk = 0;
   int         n_err = 0;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      rx_byte = b;
      rx_done = 1'b1;
      repeat (3) @(negedge clk);
      rx_done = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic push(input logic we, input logic [7:0] addr, input logic [7:0] data);
      txn_t t;
      t.we   = we;
      t.addr = addr;
      t.data = data;
      exp_q.push_back(t);
   endtask

   // Wait until only 'remain' expected bus ops are outstanding and the bus is idle.
   task automatic wait_bus(input string name, input int remain);
      int n;
      n = 0;
      while ((exp_q.size() > remain || bus_if.bus_req) && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (n >= 500) begin
         n_chk++;
         n_err++;
         $display("FAIL %s: bus wait expired, pending=%0d req=%0b expected idle", name, exp_q.size(), bus_if.bus_req);
      end
   endtask

   task automatic wait_req(input string name);
      int n;
      n = 0;
      while (!bus_if.bus_req && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) begin
         n_chk++;
         n_err++;
         $display("FAIL %s: bus_req never rose, got 0 expected 1", name);
      end
   endtask

   // Register-bus responder and scoreboard monitor.
   initial begin
      int   cnt;
      txn_t e;
      cnt = 0;
      bus_if.bus_ack   = 1'b0;
      bus_if.bus_rdata = 8'h00;
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            bus_if.bus_ack = 1'b0;
            cnt = 0;
         end else if (bus_if.bus_ack) begin
            bus_if.bus_ack = 1'b0;
         end else if (bus_if.bus_req) begin
            if (cnt < ack_delay) begin
               cnt++;
            end else begin
               cnt = 0;
               if (exp_q.size() == 0) begin
                  n_chk++;
                  n_err++;
                  $display("FAIL bus_unexpected: got we=%0b addr=0x%02h expected no request",
                           bus_if.bus_we, bus_if.bus_addr);
               end else begin
                  e = exp_q.pop_front();
                  check("bus_we", {7'b0, bus_if.bus_we}, {7'b0, e.we});
                  check("bus_addr", bus_if.bus_addr, e.addr);
                  if (e.we) check("bus_wdata", bus_if.bus_wdata, e.data);
               end
               bus_if.bus_rdata = mem[bus_if.bus_addr];
               if (bus_if.bus_we) mem[bus_if.bus_addr] = bus_if.bus_wdata;
               bus_if.bus_ack = 1'b1;
            end
         end else begin
            cnt = 0;
         end
      end
   end

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation still running, expected finish");
      $display("Result: errors=%0d of %0d checks", n_err + 1, n_chk + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
      mem[8'h3F] = 8'h5C;
      mem[8'h40] = 8'h12;
      mem[8'h41] = 8'h34;

      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      check("rst_tx", tx_byte, 8'hA0);
      check("rst_req", {7'b0, bus_if.bus_req}, 8'h00);
      check("rst_we", {7'b0, bus_if.bus_we}, 8'h00);
      check("rst_addr", bus_if.bus_addr, 8'h00);
      check("rst_wdata", bus_if.bus_wdata, 8'h00);

      // 1: write burst of two
      push(1'b1, 8'h10, 8'h11);
      push(1'b1, 8'h11, 8'h22);
      send_byte(8'h90);
      check("t1_busy", tx_byte, 8'hA1);
      send_byte(8'h10);
      send_byte(8'h11);
      wait_bus("t1_d0", 1);
      send_byte(8'h22);
      wait_bus("t1_d1", 0);
      check("t1_done", tx_byte, 8'hA0);

      // 2: single read, slow ack
      ack_delay = 5;
      push(1'b0, 8'h3F, 8'h00);
      send_byte(8'h00);
      send_byte(8'h3F);
      wait_bus("t2_rd", 0);
      check("t2_rdata", tx_byte, 8'h5C);
      send_byte(8'h00);
      check("t2_status", tx_byte, 8'hA0);

      // 3: address wrap across 0xFF
      ack_delay = 1;
      push(1'b1, 8'hFF, 8'hAA);
      push(1'b1, 8'h00, 8'hBB);
      push(1'b1, 8'h01, 8'hCC);
      send_byte(8'hA0);
      send_byte(8'hFF);
      send_byte(8'hAA);
      wait_bus("t3_d0", 2);
      send_byte(8'hBB);
      wait_bus("t3_d1", 1);
      send_byte(8'hCC);
      wait_bus("t3_d2", 0);
      check("t3_done", tx_byte, 8'hA0);

      // 4: overrun while a write is held on the bus
      ack_delay = 20;
      push(1'b1, 8'h20, 8'h55);
      send_byte(8'h80);
      send_byte(8'h20);
      send_byte(8'h55);
      wait_req("t4_req");
      send_byte(8'h77);
      wait_bus("t4_wr", 0);
      check("t4_ovr", tx_byte, 8'hA8);
      send_byte(8'hFF);
      check("t4_clr", tx_byte, 8'hA0);

      // 5: bad command, then a two-byte read
      ack_delay = 2;
      send_byte(8'h81);
      repeat (10) @(negedge clk);
      check("t5_err", tx_byte, 8'hA4);
      check("t5_noreq", {7'b0, bus_if.bus_req}, 8'h00);
      push(1'b0, 8'h40, 8'h00);
      push(1'b0, 8'h41, 8'h00);
      send_byte(8'h10);
      send_byte(8'h40);
      wait_bus("t5_r0", 1);
      check("t5_rd0", tx_byte, 8'h12);
      send_byte(8'h00);
      wait_bus("t5_r1", 0);
      check("t5_rd1", tx_byte, 8'h34);
      send_byte(8'h00);
      check("t5_end", tx_byte, 8'hA4);
      send_byte(8'hFF);
      check("t5_clr", tx_byte, 8'hA0);

      // 6: reset with a request outstanding
      ack_delay = 50;
      send_byte(8'h80);
      send_byte(8'h30);
      send_byte(8'h66);
      wait_req("t6_req");
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      check("t6_req", {7'b0, bus_if.bus_req}, 8'h00);
      check("t6_we", {7'b0, bus_if.bus_we}, 8'h00);
      check("t6_addr", bus_if.bus_addr, 8'h00);
      check("t6_wdata", bus_if.bus_wdata, 8'h00);
      check("t6_tx", tx_byte, 8'hA0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      ack_delay = 2;
      push(1'b1, 8'h05, 8'h99);
      send_byte(8'h80);
      send_byte(8'h05);
      send_byte(8'h99);
      wait_bus("t6_after", 0);
      check("t6_after_tx", tx_byte, 8'hA0);

`ifdef SPI_BRIDGE_TIMEOUT_EN
      send_byte(8'h80);
      send_byte(8'h50);
      repeat (4096 + 20) @(negedge clk);
      check("t6_tmo", tx_byte, 8'hA2);
      send_byte(8'hFF);
      check("t6_tmo_clr", tx_byte, 8'hA0);
`endif

      repeat (5) @(negedge clk);
      if (exp_q.size() != 0) begin
         n_chk++;
         n_err++;
         $display("FAIL leftover: got %0d pending bus ops expected 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
